// File: rtl/dmem_mmio_if.sv
// -----------------------------------------------------------------------------
// dmem_mmio_if
// Data-memory port between the core (master) and the memory/MMIO responder
// (slave). Loads are combinational: ReadData follows DataAdr within the cycle.
//
// Signals:
//   MemWrite   master -> slave  store strobe for the current cycle
//   DataAdr    master -> slave  32-bit byte address (bits [1:0] ignored)
//   WriteData  master -> slave  32-bit store data
//   ReadData   slave -> master  32-bit load data
// -----------------------------------------------------------------------------
interface dmem_mmio_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport master (
      output MemWrite,
      output DataAdr,
      output WriteData,
      input  ReadData
   );

   modport slave (
      input  MemWrite,
      input  DataAdr,
      input  WriteData,
      output ReadData
   );
endinterface : dmem_mmio_if

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data-memory responder for the core: a word-addressed RAM plus a 16-byte
// memory-mapped register window (LED, free-running CYCLE counter, TOHOST
// completion register, STORECNT accepted-store counter).
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, 16..4096)
//   MMIO_BASE    base of the register window (16-byte aligned)
//
// Ports:
//   clk      in   single clock, all state updates on the rising edge
//   reset    in   asynchronous, active-low reset
//   bus      slave modport of dmem_mmio_if (MemWrite/DataAdr/WriteData/ReadData)
//   led      out  8-bit LED register
//   done     out  sticky, set by any store to TOHOST
//   bus_err  out  sticky access-error flag
//
// Build option:
//   DMEM_BUSERR_EN  when defined, bus_err latches any rejected store (RO
//                   register or unmapped) and any access to an unmapped
//                   address; when undefined, bus_err is tied to 0.
//
// Register map (offset from MMIO_BASE):
//   0x0 LED       R/W  store latches WriteData[7:0]
//   0x4 CYCLE     RO   +1 every edge out of reset
//   0x8 TOHOST    R/W  store latches WriteData and sets done
//   0xC STORECNT  RO   +1 per accepted store
// -----------------------------------------------------------------------------
module dmem_mmio #(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   dmem_mmio_if.slave  bus,
   output logic [7:0]  led,
   output logic        done,
   output logic        bus_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      REG_LED      = 2'd0,
      REG_CYCLE    = 2'd1,
      REG_TOHOST   = 2'd2,
      REG_STORECNT = 2'd3
   } reg_off_e;

   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   cycle_cnt;
   logic [31:0]   tohost;
   logic [31:0]   store_cnt;

   logic          ram_hit;
   logic          mmio_hit;
   reg_off_e      reg_off;
   logic [AW-1:0] word_idx;
   logic          ram_we;
   logic          led_we;
   logic          tohost_we;
   logic          store_ok;

   // Byte-lane bits are intentionally ignored: all accesses are whole words.
   logic          unused_lane_bits;
   assign unused_lane_bits = ^bus.DataAdr[1:0];

   // ---------------------------------------------------------------------------
   // Address decode. RAM takes priority if a misconfigured window overlaps it.
   // ---------------------------------------------------------------------------
   assign ram_hit  = (bus.DataAdr[31:AW+2] == '0);
   assign mmio_hit = !ram_hit && (bus.DataAdr[31:4] == MMIO_BASE[31:4]);
   assign reg_off  = reg_off_e'(bus.DataAdr[3:2]);
   assign word_idx = bus.DataAdr[AW+1:2];

   // Store qualification. Gating with reset drops a store that coincides with
   // an asserted reset, which matters for the RAM since it has no reset path.
   assign ram_we    = reset && bus.MemWrite && ram_hit;
   assign led_we    = reset && bus.MemWrite && mmio_hit && (reg_off == REG_LED);
   assign tohost_we = reset && bus.MemWrite && mmio_hit && (reg_off == REG_TOHOST);
   assign store_ok  = ram_we || led_we || tohost_we;

   // ---------------------------------------------------------------------------
   // Load path: pure function of address and current state.
   // ---------------------------------------------------------------------------
   // NOTE: every output of an always_comb gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      bus.ReadData = '0;
      if (ram_hit) begin
         bus.ReadData = ram[word_idx];
      end else if (mmio_hit) begin
         unique case (reg_off)
            REG_LED:      bus.ReadData = {24'b0, led};
            REG_CYCLE:    bus.ReadData = cycle_cnt;
            REG_TOHOST:   bus.ReadData = tohost;
            REG_STORECNT: bus.ReadData = store_cnt;
            default:      bus.ReadData = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Data RAM.
   // ---------------------------------------------------------------------------
   // NOTE: the storage array is deliberately left out of reset; resetting it
   // would turn the array into thousands of flops and block RAM inference.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[word_idx] <= bus.WriteData;
      end
   end

   // ---------------------------------------------------------------------------
   // Memory-mapped registers.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led       <= '0;
         cycle_cnt <= '0;
         tohost    <= '0;
         store_cnt <= '0;
         done      <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (led_we) begin
            led <= bus.WriteData[7:0];
         end
         if (tohost_we) begin
            tohost <= bus.WriteData;
            done   <= 1'b1;
         end
         if (store_ok) begin
            store_cnt <= store_cnt + 32'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Access-error flag.
   // ---------------------------------------------------------------------------
`ifdef DMEM_BUSERR_EN
   logic unmapped;
   logic bad_store;

   // With no read strobe on this port, any cycle presenting an unmapped
   // address counts as a bad access; MMIO reads are always legal.
   assign unmapped  = !ram_hit && !mmio_hit;
   assign bad_store = bus.MemWrite && !store_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_err <= 1'b0;
      end else if (bad_store || unmapped) begin
         bus_err <= 1'b1;
      end
   end
`else
   assign bus_err = 1'b0;
`endif

endmodule : dmem_mmio

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
// Directed self-checking bench for dmem_mmio (DEPTH_WORDS=64,
// MMIO_BASE=FFFF_0000). Inputs change on the falling edge; combinational reads
// are sampled 1 ns after an input change, state 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

   localparam logic [31:0] A_LED      = 32'hFFFF_0000;
   localparam logic [31:0] A_CYCLE    = 32'hFFFF_0004;
   localparam logic [31:0] A_TOHOST   = 32'hFFFF_0008;
   localparam logic [31:0] A_STORECNT = 32'hFFFF_000C;
   localparam logic [31:0] A_UNMAPPED = 32'h8000_0000;

`ifdef DMEM_BUSERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] led;
   logic       done;
   logic       bus_err;

   int vectors = 0;
   int errors  = 0;

   dmem_mmio_if bus ();

   dmem_mmio #(
      .DEPTH_WORDS (64),
      .MMIO_BASE   (32'hFFFF_0000)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .led     (led),
      .done    (done),
      .bus_err (bus_err)
   );

   always #5 clk = ~clk;

   // Drive one store: set up on the falling edge, commit on the rising edge,
   // return 1 ns after the commit with the strobe dropped.
   task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.MemWrite  = 1'b1;
      bus.DataAdr   = addr;
      bus.WriteData = data;
      @(posedge clk);
      #1;
      bus.MemWrite  = 1'b0;
   endtask

   task automatic set_addr(input logic [31:0] addr);
      bus.DataAdr = addr;
      #1;
   endtask

   // Reset pulse; returns on the falling edge where reset is released.
   task automatic apply_reset();
      @(negedge clk);
      bus.MemWrite = 1'b0;
      bus.DataAdr  = 32'h0;
      reset        = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      bus.MemWrite  = 1'b0;
      bus.DataAdr   = 32'h0;
      bus.WriteData = 32'h0;
      reset         = 1'b0;
      repeat (2) @(negedge clk);
      // A store presented while reset is held must be dropped.
      bus.MemWrite  = 1'b1;
      bus.DataAdr   = A_LED;
      bus.WriteData = 32'hFF;
      @(posedge clk);
      #1;
      bus.MemWrite  = 1'b0;
      vectors++;
      if ({led, done, bus_err} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got led=%h done=%b bus_err=%b, want 0/0/0", led, done, bus_err);
      end
      set_addr(A_STORECNT);
      vectors++;
      if (bus.ReadData !== 32'd0) begin
         errors++;
         $display("FAIL reset_storecnt: got %h, want 0", bus.ReadData);
      end
      @(negedge clk);
      bus.DataAdr = A_CYCLE;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (bus.ReadData !== 32'd5) begin
         errors++;
         $display("FAIL cycle_after_5: got %0d, want 5", bus.ReadData);
      end
      // Asynchronous assertion between edges.
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if (bus.ReadData !== 32'd0) begin
         errors++;
         $display("FAIL cycle_async_reset: got %0d, want 0", bus.ReadData);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_ram();
      do_store(32'h10, 32'h1111_2222);
      @(negedge clk);
      bus.MemWrite  = 1'b1;
      bus.DataAdr   = 32'h10;
      bus.WriteData = 32'hDEAD_BEEF;
      #1;
      vectors++;
      if (bus.ReadData !== 32'h1111_2222) begin
         errors++;
         $display("FAIL ram_same_cycle: got %h, want 11112222", bus.ReadData);
      end
      @(posedge clk);
      #1;
      bus.MemWrite = 1'b0;
      vectors++;
      if (bus.ReadData !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ram_next_cycle: got %h, want deadbeef", bus.ReadData);
      end
      set_addr(32'h13);
      vectors++;
      if (bus.ReadData !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ram_byte_alias: got %h, want deadbeef", bus.ReadData);
      end
   endtask

   task automatic test_led();
      apply_reset();
      do_store(A_LED, 32'h0000_01A5);
      vectors++;
      if (led !== 8'hA5) begin
         errors++;
         $display("FAIL led_out: got %h, want a5", led);
      end
      set_addr(A_LED);
      vectors++;
      if (bus.ReadData !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL led_read: got %h, want 000000a5", bus.ReadData);
      end
      set_addr(A_STORECNT);
      vectors++;
      if (bus.ReadData !== 32'd1) begin
         errors++;
         $display("FAIL led_storecnt: got %0d, want 1", bus.ReadData);
      end
   endtask

   task automatic test_tohost();
      apply_reset();
      vectors++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL tohost_done_clear: got %b, want 0", done);
      end
      do_store(A_TOHOST, 32'h1);
      vectors++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL tohost_done_set: got %b, want 1", done);
      end
      do_store(A_TOHOST, 32'h2);
      set_addr(A_TOHOST);
      vectors++;
      if (done !== 1'b1 || bus.ReadData !== 32'h2) begin
         errors++;
         $display("FAIL tohost_overwrite: got done=%b val=%h, want 1/2", done, bus.ReadData);
      end
      set_addr(A_STORECNT);
      vectors++;
      if (bus.ReadData !== 32'd2) begin
         errors++;
         $display("FAIL tohost_storecnt: got %0d, want 2", bus.ReadData);
      end
   endtask

   task automatic test_rejected();
      apply_reset();
      // Edge 1 passes inside do_store's wait for the falling edge; edge 2 commits.
      do_store(A_CYCLE, 32'hAAAA_AAAA);
      vectors++;
      if (bus_err !== ERR_EN) begin
         errors++;
         $display("FAIL reject_ro_buserr: got %b, want %b", bus_err, ERR_EN);
      end
      do_store(A_UNMAPPED, 32'h5555_5555);
      set_addr(A_CYCLE);
      vectors++;
      if (bus.ReadData !== 32'd3) begin
         errors++;
         $display("FAIL reject_cycle: got %0d, want 3", bus.ReadData);
      end
      set_addr(A_STORECNT);
      vectors++;
      if (bus.ReadData !== 32'd0 || led !== 8'h0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reject_state: got cnt=%0d led=%h done=%b, want 0/00/0", bus.ReadData, led, done);
      end
      set_addr(A_UNMAPPED);
      vectors++;
      if (bus.ReadData !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_read: got %h, want 0", bus.ReadData);
      end
      vectors++;
      if (bus_err !== ERR_EN) begin
         errors++;
         $display("FAIL reject_buserr: got %b, want %b", bus_err, ERR_EN);
      end
   endtask

   task automatic test_boundary();
      apply_reset();
      do_store(32'h0, 32'h1234_5678);
      do_store(32'hFC, 32'hCAFE_F00D);
      set_addr(32'hFC);
      vectors++;
      if (bus.ReadData !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL ram_top_word: got %h, want cafef00d", bus.ReadData);
      end
      do_store(32'h100, 32'h0000_0BAD);
      set_addr(32'h0);
      vectors++;
      if (bus.ReadData !== 32'h1234_5678) begin
         errors++;
         $display("FAIL ram_wrap_word0: got %h, want 12345678", bus.ReadData);
      end
      set_addr(32'h100);
      vectors++;
      if (bus.ReadData !== 32'd0) begin
         errors++;
         $display("FAIL ram_past_end_read: got %h, want 0", bus.ReadData);
      end
      set_addr(A_STORECNT);
      vectors++;
      if (bus.ReadData !== 32'd2) begin
         errors++;
         $display("FAIL boundary_storecnt: got %0d, want 2", bus.ReadData);
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_led();
      test_tohost();
      test_rejected();
      test_boundary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_dmem_mmio

// File: doc/dmem_mmio.md
# dmem_mmio

- Responder for the core's data-memory port: consumes `MemWrite`, `DataAdr`, `WriteData` and returns `ReadData` in the same cycle.
- Contains a word-addressed data RAM plus a small memory-mapped register file:
  - LED output register
  - free-running cycle counter
  - store counter
  - `tohost` completion register
- Sits at the top level beside the core, replacing a bare RAM. Programs can signal completion and expose status to the bench and board.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: RAM depth in 32-bit words; power of two, 16 to 4096.
- `MMIO_BASE`, 32'hFFFF_0000: base of the 16-byte register window; must be 16-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  store strobe for the current cycle.
- `DataAdr`  in  32  byte address; bits [1:0] are ignored (word accesses only).
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data, combinational from `DataAdr`.
- `led`  out  8  LED register, low byte.
- `done`  out  1  sticky; set by any store to TOHOST.
- `bus_err`  out  1  sticky access-error flag (see Configuration).

## Operation
Address decode:
- RAM region: `DataAdr < DEPTH_WORDS*4`. Word index is `DataAdr[log2(DEPTH_WORDS)+1:2]`.
- MMIO region: `DataAdr[31:4] == MMIO_BASE[31:4]`. Offset is `DataAdr[3:2]`.
- Anything else is unmapped.

MMIO registers:
- 0x0 LED, R/W: a store latches `WriteData[7:0]`; a read returns {24'b0, led}.
- 0x4 CYCLE, RO, 32-bit: increments by 1 every cycle while out of reset; wraps from FFFF_FFFF to 0.
- 0x8 TOHOST, R/W: a store latches the full 32-bit `WriteData` and sets `done`; a read returns the latched value.
- 0xC STORECNT, RO, 32-bit: increments on every accepted store (RAM, LED or TOHOST); wraps.

Reads:
- `ReadData` is a pure function of `DataAdr` and the current state; `MemWrite` has no effect on it.
- Unmapped addresses read 0.

Stores:
- A store with `MemWrite=1` commits on the rising edge.
- Stores to CYCLE, STORECNT or unmapped addresses are rejected: no state changes and STORECNT does not count them.
- `done` stays at 1 until reset. Further TOHOST stores overwrite the value and leave `done` at 1.
- RAM contents are not reset. Reads of RAM words never written are X in simulation.

## Timing
- Load latency: 0 cycles, combinational. A load in cycle N sees every store committed at or before the edge ending cycle N-1.
- Same-cycle store and read to one address returns the old value; the new value is visible from the next cycle.
- Reset assertion (asynchronous, mid-operation) forces:
  - `led`=0
  - CYCLE=0
  - TOHOST=0
  - STORECNT=0
  - `done`=0
  - `bus_err`=0
- A store pending at the edge where reset is asserted is discarded. RAM is untouched by reset.
- First edge after reset deasserts: CYCLE goes 0 to 1.
- Simultaneous events:
  - A store to TOHOST increments STORECNT and sets `done` on the same edge.
  - CYCLE increments on every edge regardless of accesses.

## Configuration
Macro `DMEM_BUSERR_EN`.
- Defined: `bus_err` is a sticky flag set on the edge of any rejected store (RO register or unmapped address). Loads from unmapped addresses also set it; loads from the MMIO window never do. Cleared only by reset.
- Undefined: `bus_err` is tied to 0 and no error logic is built. Rejected stores are still silently ignored.

## Test plan
- Reset, then release: outputs all 0. Read 0xFFFF_0004 after 5 edges returns 5. Assert `reset` low mid-count: CYCLE returns to 0 immediately (asynchronous).
- Store 0xDEADBEEF to 0x10, then read 0x10 on the next cycle: returns 0xDEADBEEF. In the same cycle as the store, the read returns the prior contents. A read of 0x13 returns the same word.
- Store 0x1A5 to 0xFFFF_0000: `led`=0xA5. A read returns 0x0000_00A5. STORECNT reads 1.
- Store 0x1 to 0xFFFF_0008: `done`=1 on that edge. A later store of 0x2 leaves `done`=1 and TOHOST reads 2. STORECNT reads 2.
- Store to 0xFFFF_0004 and to 0x8000_0000: CYCLE keeps counting, STORECNT unchanged, and `bus_err` goes 1 with `DMEM_BUSERR_EN` defined or stays 0 without it. A read of 0x8000_0000 returns 0.
- With `DEPTH_WORDS`=64: a store to 0xFC is accepted, and a store to 0x100 is unmapped (RAM word 0 unchanged).
